// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the buffer-memory port arbiter: requester indices,
// FSM encoding and a one-hot to index helper.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_OFM = 2'd0;
  localparam req_idx_t REQ_WGT = 2'd1;
  localparam req_idx_t REQ_IFM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_t idx;
    idx = REQ_OFM;
    if (oh[REQ_WGT]) idx = REQ_WGT;
    if (oh[REQ_IFM]) idx = REQ_IFM;
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant, searching from
// the requester after the last one granted.
module rr_arbiter3
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  req_idx_t           i_last_gnt,
  output logic [NUM_REQ-1:0] o_gnt,
  output req_idx_t           o_gnt_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_pick;

  // Rotate so bit 0 is the highest-priority requester, take the lowest set
  // bit, then rotate the pick back into requester order.
  // NOTE: every output of an always_comb gets a default before any branch,
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    w_rot = i_req;
    case (i_last_gnt)
      REQ_OFM: w_rot = {i_req[0], i_req[2], i_req[1]};
      REQ_WGT: w_rot = {i_req[1], i_req[0], i_req[2]};
      default: w_rot = i_req;
    endcase

    w_pick = w_rot & (~w_rot + 3'd1);

    o_gnt = w_pick;
    case (i_last_gnt)
      REQ_OFM: o_gnt = {w_pick[1], w_pick[0], w_pick[2]};
      REQ_WGT: o_gnt = {w_pick[0], w_pick[2], w_pick[1]};
      default: o_gnt = w_pick;
    endcase
  end

  assign o_gnt_idx = onehot_to_idx(o_gnt);
  assign o_any     = |i_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the buffer-SRAM port between OFM write-back, weight fetch and IFM
// fetch: round-robin grant, whole-burst ownership, per-requester read return.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    len,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            wr_ack,
  output logic [NUM_REQ-1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [NUM_REQ-1:0]              done,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);

  state_e                 r_state;
  logic [NUM_REQ-1:0]     r_gnt;
  req_idx_t               r_owner;
  req_idx_t               r_last_gnt;
  logic [ADDR_WIDTH-1:0]  r_start;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_beat;
  logic [NUM_REQ-1:0]     r_rd_valid;

  logic [NUM_REQ-1:0]     w_arb_gnt;
  req_idx_t               w_arb_idx;
  logic                   w_arb_any;
  logic                   w_bursting;
  logic                   w_is_write;
  logic                   w_last_beat;

  rr_arbiter3 u_arb (
    .i_req      (req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_arb_gnt),
    .o_gnt_idx  (w_arb_idx),
    .o_any      (w_arb_any)
  );

  assign w_bursting  = (r_state == ST_BURST);
  assign w_is_write  = (r_owner == REQ_OFM);
  assign w_last_beat = (r_beat == r_len);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_owner    <= REQ_OFM;
      r_last_gnt <= REQ_IFM;
      r_start    <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_rd_valid <= '0;
    end else begin
      // Read data comes back one cycle after its mem_en.
      r_rd_valid <= (w_bursting && !w_is_write) ? r_gnt : '0;

      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_state    <= ST_BURST;
            r_gnt      <= w_arb_gnt;
            r_owner    <= w_arb_idx;
            r_last_gnt <= w_arb_idx;
            r_start    <= addr[w_arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_len      <= len[w_arb_idx*LEN_WIDTH +: LEN_WIDTH];
            r_beat     <= '0;
          end
        end

        ST_BURST: begin
          if (w_last_beat) begin
            r_beat <= '0;
            if (w_is_write) begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_beat <= r_beat + LEN_WIDTH'(1);
          end
        end

        ST_DRAIN: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign mem_en    = w_bursting;
  assign mem_we    = w_bursting && w_is_write;
  assign mem_addr  = w_bursting ? (r_start + ADDR_WIDTH'(r_beat)) : '0;
  assign mem_wdata = mem_we ? wr_data : '0;
  assign wr_ack    = mem_we;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = (|r_rd_valid) ? mem_rdata : '0;

  // Writes finish on their last beat; reads finish with the drained beat.
  always_comb begin
    done = '0;
    if (mem_we && w_last_beat) done[REQ_OFM] = 1'b1;
    else if (r_state == ST_DRAIN) done = r_gnt;
  end

endmodule
